// File: rtl/snake_pkg.sv
// Shared definitions for the snake sprite renderer: image codes, sprite classes,
// palette index type and per-player RGB888 palette.
package snake_pkg;

    localparam logic [3:0] HEAD_UP         = 4'd0;
    localparam logic [3:0] HEAD_DOWN       = 4'd1;
    localparam logic [3:0] HEAD_LEFT       = 4'd2;
    localparam logic [3:0] HEAD_RIGHT      = 4'd3;
    localparam logic [3:0] BODY_VERTI      = 4'd4;
    localparam logic [3:0] BODY_PARAL      = 4'd5;
    localparam logic [3:0] TURN_UP_RIGHT   = 4'd6;
    localparam logic [3:0] TURN_DOWN_RIGHT = 4'd7;
    localparam logic [3:0] TURN_UP_LEFT    = 4'd8;
    localparam logic [3:0] TURN_DOWN_LEFT  = 4'd9;
    localparam logic [3:0] TAIL_UP         = 4'd10;
    localparam logic [3:0] TAIL_DOWN       = 4'd11;
    localparam logic [3:0] TAIL_LEFT       = 4'd12;
    localparam logic [3:0] TAIL_RIGHT      = 4'd13;

    typedef enum logic [1:0] {
        SprHead = 2'd0,
        SprBody = 2'd1,
        SprTurn = 2'd2,
        SprTail = 2'd3
    } sprite_e;

    typedef logic [1:0] pal_idx_t;

    localparam int unsigned MAX_PLAYERS = 4;

    // Entry 0 of every row is transparent and never shown.
    localparam logic [23:0] PALETTE [MAX_PLAYERS][4] = '{
        '{24'h000000, 24'h30C030, 24'h1E7A1E, 24'h0A2A0A},
        '{24'h000000, 24'h3060E0, 24'h1A3A9A, 24'h0A0A3A},
        '{24'h000000, 24'hE04030, 24'h9A2A1A, 24'h3A0A0A},
        '{24'h000000, 24'hE0C030, 24'h9A8A1A, 24'h3A300A}
    };

    function automatic sprite_e code_sprite(logic [3:0] code);
        sprite_e spr;
        if (code < BODY_VERTI) begin
            spr = SprHead;
        end else if (code < TURN_UP_RIGHT) begin
            spr = SprBody;
        end else if (code < TAIL_UP) begin
            spr = SprTurn;
        end else begin
            spr = SprTail;
        end
        return spr;
    endfunction

endpackage

// File: rtl/snake_sprite_rom.sv
// Sprite bitmap ROM: four square sprites of 2^TILE_BITS pixels per edge, each pixel a
// 2-bit palette index, with a registered read.
module snake_sprite_rom
    import snake_pkg::*;
#(
    parameter int unsigned TILE_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rd_en,
    input  logic [2*TILE_BITS+1:0] addr,
    output pal_idx_t               idx
);

    localparam int unsigned EDGE = 1 << TILE_BITS;
    localparam int unsigned LAST = EDGE - 1;
    localparam int unsigned HALF = EDGE / 2;

    // Bitmaps are drawn in the canonical orientation (head/tail pointing up, body
    // vertical, turn joining top and right); the pipe rotates coordinates into them.
    function automatic pal_idx_t pixel_at(sprite_e spr, int unsigned r, int unsigned c);
        pal_idx_t px;
        px = 2'd0;
        case (spr)
            SprHead: begin
                if (r == 0)         px = 2'd0;
                else if (r < 3)     px = 2'd3;
                else if (c < HALF)  px = 2'd1;
                else                px = 2'd2;
            end
            SprBody: begin
                if (c < 2 || c > LAST - 2)        px = 2'd0;
                else if (c == 2 || c == LAST - 2) px = 2'd3;
                else if ((r % 2) != 0)            px = 2'd2;
                else                              px = 2'd1;
            end
            SprTurn: begin
                if (r < HALF) px = (c >= HALF) ? 2'd1 : 2'd3;
                else          px = (c >= HALF) ? 2'd2 : 2'd0;
            end
            SprTail: begin
                if (r >= HALF)   px = 2'd0;
                else if (c == r) px = 2'd3;
                else if (c > r)  px = 2'd2;
                else             px = 2'd1;
            end
            default: px = 2'd0;
        endcase
        return px;
    endfunction

    sprite_e              spr;
    logic [TILE_BITS-1:0] row;
    logic [TILE_BITS-1:0] col;

    assign spr = sprite_e'(addr[2*TILE_BITS+1 -: 2]);
    assign row = addr[2*TILE_BITS-1 -: TILE_BITS];
    assign col = addr[TILE_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            idx <= pixel_at(spr, 32'(row), 32'(col));
        end
    end

endmodule

// File: rtl/snake_sprite_pipe.sv
// Two-stage sprite pixel pipe: orient tile coordinates into the sprite ROM, then map
// the palette index to RGB888 with transparency and per-player blinking.
module snake_sprite_pipe
    import snake_pkg::*;
#(
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned TILE_BITS = 4,
    parameter int unsigned BLINK_W   = 4,
    localparam int unsigned PW       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [PW-1:0]        i_player,
    input  logic [3:0]           i_snake_image,
    input  logic [9:0]           i_pos_x,
    input  logic [9:0]           i_pos_y,
    input  logic [N_PLAYERS-1:0] i_blink_en,
    input  logic                 i_frame_tick,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [23:0]          o_pixel,
    output logic                 o_opaque
);

    logic                 advance;
    logic                 accept;
    logic [TILE_BITS-1:0] r;
    logic [TILE_BITS-1:0] c;
    logic [TILE_BITS-1:0] row;
    logic [TILE_BITS-1:0] col;
    sprite_e              sprite;
    logic                 code_ok;
    logic [PW-1:0]        player;
    logic [BLINK_W-1:0]   blink_q;
    logic                 phase;
    logic                 blank;
    logic                 s1_valid;
    logic                 s1_blank;
    logic [PW-1:0]        s1_player;
    pal_idx_t             rom_idx;
    logic                 s2_opaque;
    logic [1:0]           pal_sel;
    logic                 unused_pos;

    assign advance = !o_valid || i_ready;
    assign o_ready = advance;
    assign accept  = i_valid && advance;

    assign r          = i_pos_y[TILE_BITS-1:0];
    assign c          = i_pos_x[TILE_BITS-1:0];
    assign unused_pos = ^{i_pos_x[9:TILE_BITS], i_pos_y[9:TILE_BITS]};

    // Orientation: ~v is M-v for an unsigned TILE_BITS-wide coordinate.
    always_comb begin
        sprite  = code_sprite(i_snake_image);
        code_ok = (i_snake_image <= TAIL_RIGHT);
        row     = r;
        col     = c;
        case (i_snake_image)
            HEAD_DOWN, TAIL_DOWN, TURN_DOWN_RIGHT: row = ~r;
            HEAD_LEFT, TAIL_LEFT, BODY_PARAL: begin
                row = c;
                col = r;
            end
            HEAD_RIGHT, TAIL_RIGHT: begin
                row = ~c;
                col = r;
            end
            TURN_UP_LEFT: col = ~c;
            TURN_DOWN_LEFT: begin
                row = ~r;
                col = ~c;
            end
            default: ;
        endcase
    end

    assign player = (32'(i_player) >= N_PLAYERS) ? '0 : i_player;
    assign phase  = blink_q[BLINK_W-1];
    assign blank  = !code_ok || (i_blink_en[player] && phase);

    // Free-running so the blink cadence stays tied to video frames even when stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_q <= '0;
        end else if (i_frame_tick) begin
            blink_q <= blink_q + 1'b1;
        end
    end

    snake_sprite_rom #(
        .TILE_BITS (TILE_BITS)
    ) u_rom (
        .clk   (i_clk),
        .rd_en (advance),
        .addr  ({sprite, row, col}),
        .idx   (rom_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
        end
    end

    always_ff @(posedge i_clk) begin
        if (advance) begin
            s1_player <= player;
            s1_blank  <= blank;
        end
    end

    assign pal_sel   = 2'(s1_player);
    assign s2_opaque = s1_valid && !s1_blank && (rom_idx != 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_opaque <= 1'b0;
            o_pixel  <= '0;
        end else if (advance) begin
            o_valid  <= s1_valid;
            o_opaque <= s2_opaque;
            o_pixel  <= s2_opaque ? PALETTE[pal_sel][rom_idx] : 24'h000000;
        end
    end

endmodule

// File: tb/tb_snake_sprite_pipe.sv
// Scoreboard bench for snake_sprite_pipe: directed corner cases plus random traffic
// against a flip/transpose reference model of the sprite renderer.
module tb_snake_sprite_pipe;

    localparam int NP = 2;
    localparam int TB = 4;
    localparam int BW = 4;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int E  = 1 << TB;
    localparam int M  = E - 1;

    typedef struct {
        logic [23:0] pixel;
        logic        opaque;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [PW-1:0] i_player;
    logic [3:0]    img;
    logic [9:0]    px;
    logic [9:0]    py;
    logic [NP-1:0] ben;
    logic          tick;
    logic          o_valid;
    logic          i_ready;
    logic [23:0]   o_pixel;
    logic          o_opaque;

    int checks   = 0;
    int failures = 0;

    exp_t          exp_q[$];
    logic [BW-1:0] blink_m;
    bit            rand_ready = 0;
    bit            rand_tick  = 0;

    int bmap [4][E][E];
    logic [23:0] pal [4][4] = '{
        '{24'h000000, 24'h30C030, 24'h1E7A1E, 24'h0A2A0A},
        '{24'h000000, 24'h3060E0, 24'h1A3A9A, 24'h0A0A3A},
        '{24'h000000, 24'hE04030, 24'h9A2A1A, 24'h3A0A0A},
        '{24'h000000, 24'hE0C030, 24'h9A8A1A, 24'h3A300A}
    };
    // Per image code: transpose, then mirror rows, then mirror columns.
    int ori_t  [14] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    int ori_fr [14] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1};
    int ori_fc [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int quad [2][2] = '{'{3, 1}, '{0, 2}};

    snake_sprite_pipe #(
        .N_PLAYERS (NP),
        .TILE_BITS (TB),
        .BLINK_W   (BW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_player      (i_player),
        .i_snake_image (img),
        .i_pos_x       (px),
        .i_pos_y       (py),
        .i_blink_en    (ben),
        .i_frame_tick  (tick),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_pixel       (o_pixel),
        .o_opaque      (o_opaque)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(int code, int pl, int x, int y, logic [NP-1:0] be,
                                   logic ph);
        exp_t e;
        int r, c, a, b, spr, idx;
        e.pixel  = 24'h0;
        e.opaque = 1'b0;
        if (pl >= NP) pl = 0;
        if (code > 13) return e;
        r = y % E;
        c = x % E;
        a = (ori_t[code] != 0) ? c : r;
        b = (ori_t[code] != 0) ? r : c;
        if (ori_fr[code] != 0) a = M - a;
        if (ori_fc[code] != 0) b = M - b;
        spr = (code < 4) ? 0 : (code < 6) ? 1 : (code < 10) ? 2 : 3;
        idx = bmap[spr][a][b];
        if (idx == 0 || (be[pl] && ph)) return e;
        e.opaque = 1'b1;
        e.pixel  = pal[pl][idx];
        return e;
    endfunction

    // Monitor/scoreboard: everything decided at negedge reflects the coming posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                blink_m = '0;
            end else begin
                chk("handshake_o_ready", {31'b0, o_ready}, {31'b0, (!o_valid || i_ready)});
                if (o_valid && i_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output got pixel=%06h opaque=%0b required none",
                                 o_pixel, o_opaque);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_pixel !== e.pixel || o_opaque !== e.opaque) begin
                            failures++;
                            $display("FAIL scoreboard got pixel=%06h opaque=%0b required pixel=%06h opaque=%0b",
                                     o_pixel, o_opaque, e.pixel, e.opaque);
                        end
                    end
                end
                if (i_valid && o_ready) begin
                    exp_q.push_back(model(int'(img), int'(i_player), int'(px), int'(py), ben,
                                          blink_m[BW-1]));
                end
                if (tick) blink_m = blink_m + 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) i_ready = ($urandom_range(0, 9) < 7);
            if (rand_tick)  tick    = ($urandom_range(0, 5) == 0);
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic send(input int code, input int pl, input int x, input int y);
        i_valid  = 1'b1;
        img      = 4'(code);
        i_player = PW'(pl);
        px       = 10'(x);
        py       = 10'(y);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (o_ready) begin
                @(posedge clk);
                #1;
                i_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL send_timeout got=no_accept required=accept");
        i_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < E; r++) begin
                for (int c = 0; c < E; c++) begin
                    case (s)
                        0: bmap[s][r][c] = (r == 0) ? 0 : (r < 3) ? 3 : (c < E / 2) ? 1 : 2;
                        1: bmap[s][r][c] = (c < 2 || c > E - 3) ? 0 :
                                           (c == 2 || c == E - 3) ? 3 : (r % 2 == 1) ? 2 : 1;
                        2: bmap[s][r][c] = quad[r / (E / 2)][c / (E / 2)];
                        default: bmap[s][r][c] = (r >= E / 2) ? 0 : (c == r) ? 3 :
                                                 (c > r) ? 2 : 1;
                    endcase
                end
            end
        end

        rst = 1'b1; i_valid = 1'b0; i_player = '0; img = '0; px = '0; py = '0;
        ben = '0; tick = 1'b0; i_ready = 1'b1; blink_m = '0;
        repeat (3) step();
        chk("reset_o_valid", {31'b0, o_valid}, 32'd0);
        chk("reset_o_pixel", {8'b0, o_pixel}, 32'd0);
        chk("reset_o_opaque", {31'b0, o_opaque}, 32'd0);
        rst = 1'b0;
        chk("post_reset_o_ready", {31'b0, o_ready}, 32'd1);

        // HEAD_UP at x=3, y=5: two-cycle latency, primary colour of player 0.
        send(0, 0, 3, 5);
        chk("latency_not_yet", {31'b0, o_valid}, 32'd0);
        step();
        chk("latency_valid", {31'b0, o_valid}, 32'd1);
        chk("head_up_pixel", {8'b0, o_pixel}, 32'h30C030);
        chk("head_up_opaque", {31'b0, o_opaque}, 32'd1);

        // Turn corners at the tile origin land in four different quadrants.
        for (int k = 6; k <= 9; k++) send(k, 0, 0, 0);
        repeat (3) step();

        send(15, 0, 3, 5);
        step();
        chk("code15_opaque", {31'b0, o_opaque}, 32'd0);
        chk("code15_pixel", {8'b0, o_pixel}, 32'd0);
        send(0, 0, 3, 0);
        step();
        chk("index0_opaque", {31'b0, o_opaque}, 32'd0);
        chk("index0_pixel", {8'b0, o_pixel}, 32'd0);
        repeat (2) step();

        fork
            begin
                send(0, 0, 1, 4);
                send(4, 1, 6, 7);
                send(10, 0, 9, 2);
                send(13, 1, 12, 14);
            end
            begin
                step();
                step();
                i_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_o_ready", {31'b0, o_ready}, 32'd0);
                    step();
                end
                i_ready = 1'b1;
            end
        join
        repeat (4) step();

        ben = 2'b10;
        for (int k = 0; k < 8; k++) begin
            tick = 1'b1;
            send(0, 1, 3, 5);
            tick = 1'b0;
            send(0, 0, 3, 5);
        end
        repeat (3) step();
        send(0, 1, 3, 5);
        step();
        chk("blink_p1_opaque", {31'b0, o_opaque}, 32'd0);
        send(0, 0, 3, 5);
        step();
        chk("blink_p0_opaque", {31'b0, o_opaque}, 32'd1);
        repeat (2) step();

        rand_ready = 1;
        rand_tick  = 1;
        for (int n = 0; n < 300; n++) begin
            ben = NP'($urandom);
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, NP - 1)),
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_ready = 0;
        rand_tick  = 0;
        i_ready    = 1'b1;
        tick       = 1'b0;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) step();
        chk("random_drain", exp_q.size(), 32'd0);

        // Two pixels in flight when reset hits: both must vanish.
        send(0, 0, 3, 5);
        send(3, 1, 7, 8);
        rst = 1'b1;
        step();
        chk("midreset_o_valid", {31'b0, o_valid}, 32'd0);
        rst = 1'b0;
        chk("midreset_o_ready", {31'b0, o_ready}, 32'd1);
        repeat (4) begin
            step();
            chk("no_stale_output", {31'b0, o_valid}, 32'd0);
        end

        send(5, 1, 2, 9);
        send(11, 0, 4, 3);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
        chk("final_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
